// File: rtl/muldiv_issue_arb.sv
// rtl/muldiv_issue_arb.sv - round-robin issue arbiter for the shared mul/div/clmul unit
module muldiv_issue_arb #(
  parameter int NREQ       = 2,
  parameter int LNREQ      = 1,
  parameter int RV         = 64,
  parameter int CNTRL_SIZE = 7,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int HW         = (NHART > 1 && LNHART > 0) ? LNHART : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*CNTRL_SIZE-1:0] req_control,
  input  logic [NREQ*LNCOMMIT-1:0]   req_rd,
  input  logic [NREQ-1:0]            req_makes_rd,
  input  logic [NREQ*HW-1:0]         req_hart,
  input  logic [NREQ*RV-1:0]         req_r1,
  input  logic [NREQ*RV-1:0]         req_r2,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NCOMMIT-1:0]         commit_kill_0,
  input  logic                       divide_busy,
  output logic                       enable,
  output logic [CNTRL_SIZE-1:0]      control,
  output logic [LNCOMMIT-1:0]        rd,
  output logic                       makes_rd,
  output logic [HW-1:0]              hart,
  output logic [RV-1:0]              r1,
  output logic [RV-1:0]              r2
);

  logic [LNREQ-1:0] rr_ptr;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [LNREQ-1:0] win;
  logic             found;
  logic             div_block;
  logic [RV-1:0]    op1_q;
  logic [RV-1:0]    op2_q;

  // Eligibility and round-robin pick; a divide launching this cycle already blocks the next divide
  always_comb begin
    div_block = divide_busy || (enable && !control[0] && !control[5]);
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i]
             && !commit_kill_0[req_rd[i*LNCOMMIT +: LNCOMMIT]]
             && !(!req_control[i*CNTRL_SIZE] && !req_control[i*CNTRL_SIZE+5] && div_block);
    end
    grant = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      automatic int idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        win        = idx[LNREQ-1:0];
        grant[idx] = 1'b1;
      end
    end
    req_ready = grant & {NREQ{reset}};
  end

  // Launch stage: the winner's op is presented to the unit the cycle after grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      control  <= '0;
      rd       <= '0;
      makes_rd <= 1'b0;
      hart     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      enable <= found;
      if (found) begin
        control  <= req_control[win*CNTRL_SIZE +: CNTRL_SIZE];
        rd       <= req_rd[win*LNCOMMIT +: LNCOMMIT];
        makes_rd <= req_makes_rd[win];
        hart     <= req_hart[win*HW +: HW];
        op1_q    <= req_r1[win*RV +: RV];
        op2_q    <= req_r2[win*RV +: RV];
      end
    end
  end

  // Operand stage: r1/r2 trail enable by one cycle and hold between launches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1 <= '0;
      r2 <= '0;
    end else if (enable) begin
      r1 <= op1_q;
      r2 <= op2_q;
    end
  end

  // Round-robin pointer moves just past the winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      if (int'(win) == NREQ - 1) rr_ptr <= '0;
      else                       rr_ptr <= win + 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_arb.sv
// tb/tb_muldiv_issue_arb.sv - self-checking bench for muldiv_issue_arb
module tb_muldiv_issue_arb;
  localparam int NREQ = 2;
  localparam int CS   = 7;
  localparam int LC   = 5;
  localparam int RV   = 64;
  localparam int HW   = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*CS-1:0] req_control = '0;
  logic [NREQ*LC-1:0] req_rd = '0;
  logic [NREQ-1:0] req_makes_rd = '0;
  logic [NREQ*HW-1:0] req_hart = '0;
  logic [NREQ*RV-1:0] req_r1 = '0;
  logic [NREQ*RV-1:0] req_r2 = '0;
  logic [NREQ-1:0] req_ready;
  logic [31:0]     commit_kill_0 = '0;
  logic            divide_busy = 1'b0;
  logic            enable;
  logic [CS-1:0]   control;
  logic [LC-1:0]   rd;
  logic            makes_rd;
  logic [HW-1:0]   hart;
  logic [RV-1:0]   r1, r2;

  always #5 clk = ~clk;

  muldiv_issue_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_control(req_control),
    .req_rd(req_rd), .req_makes_rd(req_makes_rd), .req_hart(req_hart),
    .req_r1(req_r1), .req_r2(req_r2), .req_ready(req_ready),
    .commit_kill_0(commit_kill_0), .divide_busy(divide_busy), .enable(enable),
    .control(control), .rd(rd), .makes_rd(makes_rd), .hart(hart), .r1(r1), .r2(r2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: list of granted ops with the cycle they were granted in
  typedef struct {
    int           cyc;
    logic [6:0]   ctl;
    logic [4:0]   rd;
    logic         mk;
    logic         hart;
    logic [63:0]  r1;
    logic [63:0]  r2;
  } launch_t;

  launch_t hist[$];
  int      ptr = 0;
  logic [NREQ-1:0] last_ready;
  logic            last_en;
  logic [63:0]     last_r1, last_r2;

  function automatic logic is_div(logic [6:0] c);
    return !c[0] && !c[5];
  endfunction

  task automatic model_reset();
    hist.delete();
    ptr = 0;
  endtask

  task automatic set_req(int i, logic [6:0] c, logic [4:0] d, logic [63:0] a, logic [63:0] b);
    req_control[i*CS +: CS] = c;
    req_rd[i*LC +: LC]      = d;
    req_r1[i*RV +: RV]      = a;
    req_r2[i*RV +: RV]      = b;
  endtask

  // One clock: compare every output at the negedge against the model, then advance the model
  task automatic step();
    launch_t last, opnd;
    logic en_e, blk;
    logic [NREQ-1:0] rdy_e;
    int win;
    @(negedge clk);
    last = '{0, 7'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0};
    opnd = last;
    en_e = 1'b0;
    if (hist.size() > 0) begin
      last = hist[hist.size()-1];
      en_e = (last.cyc == cyc - 1);
    end
    for (int j = hist.size() - 1; j >= 0; j--) begin
      if (hist[j].cyc <= cyc - 2) begin
        opnd = hist[j];
        break;
      end
    end
    rdy_e = '0;
    win = -1;
    if (reset) begin
      blk = divide_busy || (en_e && is_div(last.ctl));
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (win < 0 && req_valid[i] && !commit_kill_0[req_rd[i*LC +: LC]]
            && !(is_div(req_control[i*CS +: CS]) && blk))
          win = i;
      end
      if (win >= 0) rdy_e[win] = 1'b1;
    end
    chk("req_ready", req_ready, rdy_e);
    chk("enable", enable, en_e);
    chk("control", control, last.ctl);
    chk("rd", rd, last.rd);
    chk("makes_rd", makes_rd, last.mk);
    chk("hart", hart, last.hart);
    chk("r1", r1, opnd.r1);
    chk("r2", r2, opnd.r2);
    last_ready = req_ready;
    last_en    = enable;
    last_r1    = r1;
    last_r2    = r2;
    @(posedge clk);
    if (reset && win >= 0) begin
      hist.push_back('{cyc, req_control[win*CS +: CS], req_rd[win*LC +: LC],
                       req_makes_rd[win], req_hart[win], req_r1[win*RV +: RV], req_r2[win*RV +: RV]});
      ptr = (win + 1) % NREQ;
    end
    while (hist.size() > 3) void'(hist.pop_front());
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    step();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [6:0]  c0, c1;
    logic [4:0]  rd0, rd1;
    logic [31:0] kill;
    logic        busy;
    logic [1:0]  exp;
  } vec_t;

  vec_t vt[11];
  int   seen;

  initial begin
    // Combinational arbitration vectors, pointer at 0 and nothing in flight
    vt[0]  = '{2'b11, 7'h01, 7'h01, 5'd0, 5'd1, 32'h0,        1'b0, 2'b01};
    vt[1]  = '{2'b10, 7'h01, 7'h01, 5'd0, 5'd1, 32'h0,        1'b0, 2'b10};
    vt[2]  = '{2'b00, 7'h01, 7'h01, 5'd0, 5'd1, 32'h0,        1'b0, 2'b00};
    vt[3]  = '{2'b11, 7'h01, 7'h01, 5'd4, 5'd1, 32'h10,       1'b0, 2'b10};
    vt[4]  = '{2'b11, 7'h00, 7'h00, 5'd0, 5'd1, 32'h0,        1'b1, 2'b00};
    vt[5]  = '{2'b11, 7'h00, 7'h01, 5'd0, 5'd1, 32'h0,        1'b1, 2'b10};
    vt[6]  = '{2'b11, 7'h20, 7'h00, 5'd0, 5'd1, 32'h0,        1'b1, 2'b01};
    vt[7]  = '{2'b11, 7'h01, 7'h01, 5'd2, 5'd9, 32'h204,      1'b0, 2'b00};
    vt[8]  = '{2'b01, 7'h00, 7'h00, 5'd0, 5'd1, 32'h0,        1'b0, 2'b01};
    vt[9]  = '{2'b11, 7'h1e, 7'h00, 5'd0, 5'd1, 32'h0,        1'b0, 2'b01};
    vt[10] = '{2'b11, 7'h01, 7'h01, 5'd2, 5'd3, 32'h8,        1'b0, 2'b01};

    // Reset held with both requesters valid
    req_valid = 2'b11;
    set_req(0, 7'h01, 5'd0, 64'd1, 64'd2);
    set_req(1, 7'h01, 5'd1, 64'd3, 64'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_enable", enable, 1'b0);
    chk("rst_r1", r1, 64'd0);
    chk("rst_r2", r2, 64'd0);

    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      reset = 1'b0;
      req_valid = vt[v].valid;
      set_req(0, vt[v].c0, vt[v].rd0, 64'd0, 64'd0);
      set_req(1, vt[v].c1, vt[v].rd1, 64'd0, 64'd0);
      commit_kill_0 = vt[v].kill;
      divide_busy = vt[v].busy;
      #1 reset = 1'b1;
      #1 chk($sformatf("vec%0d", v), req_ready, vt[v].exp);
      reset = 1'b0;
      req_valid = '0;
      commit_kill_0 = '0;
      divide_busy = 1'b0;
    end

    // Release with both mul requesters pending; then round-robin
    @(posedge clk);
    #1;
    model_reset();
    req_valid = 2'b11;
    req_makes_rd = 2'b10;
    req_hart = 2'b01;
    set_req(0, 7'h01, 5'd6, 64'h11, 64'h12);
    set_req(1, 7'h21, 5'd7, 64'h21, 64'h22);
    reset = 1'b1;
    step();
    chk("first_grant", last_ready, 2'b01);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_alt", last_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_enable", last_en, 1'b1);
    end

    // Operand timing
    do_reset();
    req_valid = 2'b01;
    set_req(0, 7'h01, 5'd2, 64'd5, 64'd7);
    step();
    set_req(0, 7'h01, 5'd2, 64'd3, 64'd4);
    step();
    req_valid = 2'b00;
    step();
    chk("op_en_s2", last_en, 1'b1);
    chk("op_r1_s2", last_r1, 64'd5);
    chk("op_r2_s2", last_r2, 64'd7);
    step();
    chk("op_en_s3", last_en, 1'b0);
    chk("op_r1_s3", last_r1, 64'd3);
    chk("op_r2_s3", last_r2, 64'd4);
    step();
    chk("op_hold", last_r1, 64'd3);

    // Kill on req0's destination
    do_reset();
    req_valid = 2'b11;
    set_req(0, 7'h01, 5'd4, 64'd1, 64'd1);
    set_req(1, 7'h01, 5'd5, 64'd2, 64'd2);
    commit_kill_0 = 32'h10;
    step();
    chk("kill_skip", last_ready, 2'b10);
    commit_kill_0 = 32'h0;
    step();
    chk("kill_ptr", last_ready, 2'b01);

    // Divide blocking
    do_reset();
    req_valid = 2'b11;
    set_req(0, 7'h00, 5'd1, 64'd100, 64'd7);
    set_req(1, 7'h00, 5'd2, 64'd50, 64'd5);
    step();
    chk("div_grant0", last_ready, 2'b01);
    req_valid = 2'b10;
    set_req(1, 7'h01, 5'd2, 64'd6, 64'd6);
    step();
    chk("div_mul_pass", last_ready, 2'b10);
    set_req(1, 7'h00, 5'd3, 64'd9, 64'd3);
    divide_busy = 1'b1;
    seen = 0;
    for (int k = 0; k < 39; k++) begin
      step();
      if (last_ready[1]) seen++;
    end
    chk("div_blocked", seen, 0);
    divide_busy = 1'b0;
    step();
    chk("div_release", last_ready, 2'b10);
    req_valid = 2'b00;
    step();

    // Async reset in the middle of a divide
    do_reset();
    req_valid = 2'b01;
    set_req(0, 7'h00, 5'd1, 64'd77, 64'd3);
    step();
    req_valid = 2'b00;
    step();
    divide_busy = 1'b1;
    repeat (8) step();
    #2;
    reset = 1'b0;
    divide_busy = 1'b0;
    #1;
    chk("amid_enable", enable, 1'b0);
    chk("amid_control", control, 7'd0);
    chk("amid_r1", r1, 64'd0);
    chk("amid_r2", r2, 64'd0);
    model_reset();
    step();
    reset = 1'b1;
    repeat (3) step();
    req_valid = 2'b11;
    set_req(1, 7'h01, 5'd2, 64'd8, 64'd9);
    step();
    chk("amid_rearb", last_ready, 2'b01);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      req_valid = NREQ'($urandom);
      req_makes_rd = NREQ'($urandom);
      req_hart = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, 7'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
      commit_kill_0 = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 7)) : 32'h0;
      if ($urandom_range(0, 3) == 0) divide_busy = ~divide_busy;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
